// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage. Owns the PC, issues req/ack fetches
// to instruction memory and presents instruction + PC+4 to the IF/ID register.
// Handles hazard stalls (PCWrite) and EX redirects (pc_src), including
// redirects that arrive while a fetch is still outstanding.
// Optional feature macro: IF_MISALIGN_CHECK_EN (reject redirect targets whose
// low two bits are non-zero and pulse IF_misalign instead).
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        startin_n,
  input  logic        PCWrite,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_instr,
  output logic [31:0] IF_pc_plus_4,
  output logic        IF_valid,
  output logic        IF_misalign
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]  state_r, state_n_s;
  logic [31:0] pc_r, pc_n_s;
  logic        redir_pend_r, redir_pend_n_s;
  logic [31:0] redir_pc_r, redir_pc_n_s;
  logic        req_r, req_n_s;
  logic [31:0] instr_r, instr_n_s;
  logic [31:0] pc_plus_4_r, pc_plus_4_n_s;
  logic        valid_r, valid_n_s;
  logic        misalign_r, misalign_n_s;
  logic        misaligned_s;
  logic [31:0] eff_target_s;
  logic [31:0] pc_inc_s;

`ifdef IF_MISALIGN_CHECK_EN
  assign misaligned_s = (branch_target[1:0] != 2'b00);
`else
  assign misaligned_s = 1'b0;
`endif

  // A rejected (misaligned) redirect still flushes, but re-targets the current pc.
  assign eff_target_s = misaligned_s ? pc_r : branch_target;
  assign pc_inc_s     = pc_r + 32'd4;

  // Next-state and next-output computation for the fetch sequencer.
  always_comb begin
    state_n_s      = state_r;
    pc_n_s         = pc_r;
    redir_pend_n_s = redir_pend_r;
    redir_pc_n_s   = redir_pc_r;
    instr_n_s      = instr_r;
    pc_plus_4_n_s  = pc_plus_4_r;
    valid_n_s      = valid_r;
    case (state_r)
      ST_IDLE: begin
        state_n_s = ST_FETCH;
        if (pc_src) begin
          pc_n_s = eff_target_s;
        end else begin
          pc_n_s = pc_r;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          if (pc_src) begin
            // Same-cycle redirect: returned word is wrong-path, drop it.
            pc_n_s         = eff_target_s;
            redir_pend_n_s = 1'b0;
          end else if (redir_pend_r) begin
            // Earlier redirect was parked until this ack; discard data.
            pc_n_s         = redir_pc_r;
            redir_pend_n_s = 1'b0;
          end else begin
            instr_n_s     = imem_rdata;
            pc_plus_4_n_s = pc_inc_s;
            valid_n_s     = 1'b1;
            state_n_s     = ST_HOLD;
          end
        end else if (pc_src) begin
          // Address must stay stable while the request is open; park target.
          redir_pend_n_s = 1'b1;
          redir_pc_n_s   = eff_target_s;
        end else begin
          state_n_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (pc_src) begin
          pc_n_s        = eff_target_s;
          valid_n_s     = 1'b0;
          instr_n_s     = NOP_INSTR;
          pc_plus_4_n_s = 32'h0000_0000;
          state_n_s     = ST_FETCH;
        end else if (PCWrite) begin
          pc_n_s        = pc_inc_s;
          valid_n_s     = 1'b0;
          instr_n_s     = NOP_INSTR;
          pc_plus_4_n_s = 32'h0000_0000;
          state_n_s     = ST_FETCH;
        end else begin
          state_n_s = ST_HOLD;
        end
      end
      default: begin
        state_n_s      = ST_IDLE;
        pc_n_s         = RESET_PC;
        redir_pend_n_s = 1'b0;
        valid_n_s      = 1'b0;
        instr_n_s      = NOP_INSTR;
        pc_plus_4_n_s  = 32'h0000_0000;
      end
    endcase
    req_n_s      = (state_n_s == ST_FETCH);
    misalign_n_s = pc_src && misaligned_s;
  end

  // State and output registers; reset abandons any open request at once.
  always_ff @(posedge clk or negedge startin_n) begin
    if (!startin_n) begin
      state_r      <= ST_IDLE;
      pc_r         <= RESET_PC;
      redir_pend_r <= 1'b0;
      redir_pc_r   <= RESET_PC;
      req_r        <= 1'b0;
      instr_r      <= NOP_INSTR;
      pc_plus_4_r  <= 32'h0000_0000;
      valid_r      <= 1'b0;
      misalign_r   <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      pc_r         <= pc_n_s;
      redir_pend_r <= redir_pend_n_s;
      redir_pc_r   <= redir_pc_n_s;
      req_r        <= req_n_s;
      instr_r      <= instr_n_s;
      pc_plus_4_r  <= pc_plus_4_n_s;
      valid_r      <= valid_n_s;
      misalign_r   <= misalign_n_s;
    end
  end

  assign imem_req     = req_r;
  assign imem_addr    = pc_r;
  assign IF_instr     = instr_r;
  assign IF_pc_plus_4 = pc_plus_4_r;
  assign IF_valid     = valid_r;
  assign IF_misalign  = misalign_r;

endmodule
